// File: rtl/vram_cpu_port.sv
// HuC6270 CPU-side VRAM access port: MAWR/MARR/VWR/VRR registers behind the 8-bit bus,
// slot-gated VRAM read/write issue. Optional VRAM_PORT_OVERRUN_EN adds a sticky dropped-trigger flag.
module vram_cpu_port #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        cpu_a,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  input  logic [1:0]        incr_sel,
  input  logic              slot_avail,
  output logic [ADDR_W-1:0] MA,
  output logic              re,
  output logic              we,
  output logic [DATA_W-1:0] MD_in,
  input  logic [DATA_W-1:0] MD_out,
`ifdef VRAM_PORT_OVERRUN_EN
  output logic              overrun,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WR_PEND, RD_PEND, RD_WAIT} state_t;

  state_t              state, state_nx;
  logic [4:0]          ar;
  logic [ADDR_W-1:0]   mawr, marr, ma_q, inc;
  logic [7:0]          vwr_lo;
  logic [DATA_W-1:0]   wdata, vrr;
  logic                wr_lo, wr_hi, rd_vrr, wr_trig, rd_trig, issue_wr, issue_rd;

  function automatic logic [ADDR_W-1:0] put_byte(input logic [ADDR_W-1:0] r,
                                                 input logic [7:0] b, input logic hi);
    logic [15:0] t;
    t = 16'(r);
    if (hi) t[15:8] = b;
    else    t[7:0]  = b;
    return ADDR_W'(t);
  endfunction

  assign wr_lo    = cpu_wr && (cpu_a == 2'd2);
  assign wr_hi    = cpu_wr && (cpu_a == 2'd3);
  assign rd_vrr   = cpu_rd && (cpu_a == 2'd3) && (ar == 5'd2);
  assign wr_trig  = wr_hi && (ar == 5'd2);
  assign rd_trig  = (wr_hi && (ar == 5'd1)) || rd_vrr;
  // Strobes are suppressed during reset so an abandoned access never reaches VRAM.
  assign issue_wr = (state == WR_PEND) && slot_avail && !reset;
  assign issue_rd = (state == RD_PEND) && slot_avail && !reset;
  assign busy     = (state != IDLE);
  assign MD_in    = wdata;

  always_comb begin
    case (incr_sel)
      2'd0:    inc = ADDR_W'(1);
      2'd1:    inc = ADDR_W'(32);
      2'd2:    inc = ADDR_W'(64);
      default: inc = ADDR_W'(128);
    endcase
  end

  always_comb begin
    state_nx = state;
    we       = issue_wr;
    re       = issue_rd;
    MA       = ma_q;
    if (issue_wr)      MA = mawr;
    else if (issue_rd) MA = marr;
    case (state)
      IDLE: begin
        if (wr_trig)      state_nx = WR_PEND;
        else if (rd_trig) state_nx = RD_PEND;
      end
      WR_PEND: if (slot_avail) state_nx = IDLE;
      RD_PEND: if (slot_avail) state_nx = RD_WAIT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      ar     <= '0;
      mawr   <= '0;
      marr   <= '0;
      ma_q   <= '0;
      vwr_lo <= '0;
      wdata  <= '0;
      vrr    <= '0;
    end else begin
      state <= state_nx;
      ma_q  <= MA;
      if (cpu_wr && (cpu_a == 2'd0)) ar <= cpu_din[4:0];
      if (wr_lo && (ar == 5'd2)) vwr_lo <= cpu_din;
      if ((state == IDLE) && wr_trig) wdata <= DATA_W'({cpu_din, vwr_lo});
      // A CPU write to MAWR beats the post-write increment landing on the same edge.
      if (wr_lo && (ar == 5'd0))      mawr <= put_byte(mawr, cpu_din, 1'b0);
      else if (wr_hi && (ar == 5'd0)) mawr <= put_byte(mawr, cpu_din, 1'b1);
      else if (issue_wr)              mawr <= mawr + inc;
      if (wr_lo && (ar == 5'd1))      marr <= put_byte(marr, cpu_din, 1'b0);
      else if (wr_hi && (ar == 5'd1)) marr <= put_byte(marr, cpu_din, 1'b1);
      else if (rd_vrr)                marr <= marr + inc;
      if (state == RD_WAIT) vrr <= MD_out;
    end
  end

`ifdef VRAM_PORT_OVERRUN_EN
  always_ff @(posedge clock) begin
    if (reset)                                overrun <= 1'b0;
    else if ((wr_trig || rd_trig) && busy)    overrun <= 1'b1;
    else if (cpu_rd && (cpu_a == 2'd0))       overrun <= 1'b0;
  end
`endif

  always_comb begin
    cpu_dout = '0;
    case (cpu_a)
`ifdef VRAM_PORT_OVERRUN_EN
      2'd0: cpu_dout = {overrun, 2'b0, ar};
`else
      2'd0: cpu_dout = {3'b0, ar};
`endif
      2'd2: cpu_dout = vrr[7:0];
      2'd3: cpu_dout = vrr[15:8];
      default: cpu_dout = '0;
    endcase
  end

endmodule

// File: tb/tb_vram_cpu_port.sv
// Directed table-driven bench for vram_cpu_port with a behavioural VRAM responder.
module tb_vram_cpu_port;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cpu_a = '0;
  logic        cpu_wr = 1'b0, cpu_rd = 1'b0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic [1:0]  incr_sel = '0;
  logic        slot_avail = 1'b0;
  logic [15:0] MA, MD_in;
  logic [15:0] MD_out = '0;
  logic        re, we, busy;
`ifdef VRAM_PORT_OVERRUN_EN
  logic        overrun;
`endif

  vram_cpu_port #(.ADDR_W(16), .DATA_W(16)) dut (
    .clock(clock), .reset(reset), .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .incr_sel(incr_sel), .slot_avail(slot_avail),
    .MA(MA), .re(re), .we(we), .MD_in(MD_in), .MD_out(MD_out),
`ifdef VRAM_PORT_OVERRUN_EN
    .overrun(overrun),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:65535];
  int we_cnt = 0, re_cnt = 0, both_cnt = 0;
  always @(posedge clock) begin
    if (we) begin mem[MA] <= MD_in; we_cnt++; end
    if (re) begin MD_out <= mem[MA]; re_cnt++; end
    if (re && we) both_cnt++;
  end

  int total = 0, bad = 0, row = 0;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
    end
  endtask

  typedef struct {
    bit wr, rd; logic [1:0] a; logic [7:0] din; logic [1:0] isel; bit slot;
    bit busy, we, re; bit cma; logic [15:0] ma; bit cmd; logic [15:0] md; bit cdo; logic [7:0] dout;
  } vec_t;
  vec_t tbl[$];

  // op: "W" write, "R" read, "I" idle
  function automatic vec_t V(input string op, input logic [1:0] a, input logic [7:0] din,
                             input logic [1:0] isel, input bit slot, input bit b, input bit w,
                             input bit r, input bit cma, input logic [15:0] ma, input bit cmd,
                             input logic [15:0] md, input bit cdo, input logic [7:0] dout);
    vec_t v;
    v.wr = (op == "W"); v.rd = (op == "R"); v.a = a; v.din = din; v.isel = isel; v.slot = slot;
    v.busy = b; v.we = w; v.re = r; v.cma = cma; v.ma = ma; v.cmd = cmd; v.md = md;
    v.cdo = cdo; v.dout = dout;
    return v;
  endfunction

  logic [7:0] ovr_flag;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h0040] = 16'hBEEF;
    mem[16'hFFC0] = 16'h1357;
    mem[16'h0041] = 16'h2468;
`ifdef VRAM_PORT_OVERRUN_EN
    ovr_flag = 8'h82;
`else
    ovr_flag = 8'h02;
`endif

    // write path
    tbl.push_back(V("W",0,8'h00,0,1, 0,0,0, 0,0,0,0, 1,8'h00));
    tbl.push_back(V("W",2,8'h34,0,1, 0,0,0, 0,0,0,0, 1,8'h00));
    tbl.push_back(V("W",3,8'h12,0,1, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("W",0,8'h02,0,1, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("W",2,8'hCD,0,1, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("W",3,8'hAB,0,1, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("I",0,8'h00,0,1, 1,1,0, 1,16'h1234,1,16'hABCD, 1,8'h02));
    tbl.push_back(V("I",0,8'h00,0,1, 0,0,0, 1,16'h1234,1,16'hABCD, 0,0));
    tbl.push_back(V("W",3,8'h55,0,1, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("I",0,8'h00,0,1, 1,1,0, 1,16'h1235,1,16'h55CD, 0,0));
    tbl.push_back(V("I",0,8'h00,0,1, 0,0,0, 0,0,0,0, 0,0));
    // slot stall plus a dropped trigger
    tbl.push_back(V("W",3,8'h77,0,0, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("I",0,8'h00,0,0, 1,0,0, 1,16'h1235,1,16'h77CD, 0,0));
    tbl.push_back(V("W",3,8'h99,0,0, 1,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("I",0,8'h00,0,0, 1,0,0, 0,0,1,16'h77CD, 0,0));
    tbl.push_back(V("I",0,8'h00,0,0, 1,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("I",0,8'h00,0,0, 1,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("I",0,8'h00,0,1, 1,1,0, 1,16'h1236,1,16'h77CD, 0,0));
    tbl.push_back(V("I",0,8'h00,0,1, 0,0,0, 0,0,1,16'h77CD, 0,0));
    tbl.push_back(V("R",0,8'h00,0,1, 0,0,0, 0,0,0,0, 1,ovr_flag));
    tbl.push_back(V("R",0,8'h00,0,1, 0,0,0, 0,0,0,0, 1,8'h02));
    // read prefetch
    tbl.push_back(V("W",0,8'h01,0,1, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("W",2,8'h40,0,1, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("W",3,8'h00,0,1, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("I",0,8'h00,0,1, 1,0,1, 1,16'h0040,0,0, 0,0));
    tbl.push_back(V("I",0,8'h00,0,1, 1,0,0, 1,16'h0040,0,0, 0,0));
    tbl.push_back(V("I",2,8'h00,0,1, 0,0,0, 0,0,0,0, 1,8'hEF));
    tbl.push_back(V("I",3,8'h00,0,1, 0,0,0, 0,0,0,0, 1,8'hBE));
    // +128 auto-increment wrapping past 0xFFFF
    tbl.push_back(V("W",2,8'hC0,3,1, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("W",3,8'hFF,3,1, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("I",0,8'h00,3,1, 1,0,1, 1,16'hFFC0,0,0, 0,0));
    tbl.push_back(V("I",0,8'h00,3,1, 1,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("W",0,8'h02,3,1, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("R",3,8'h00,3,1, 0,0,0, 0,0,0,0, 1,8'h13));
    tbl.push_back(V("I",0,8'h00,3,1, 1,0,1, 1,16'h0040,0,0, 0,0));
    tbl.push_back(V("I",0,8'h00,3,1, 1,0,0, 0,0,0,0, 0,0));
    tbl.push_back(V("I",2,8'h00,0,1, 0,0,0, 0,0,0,0, 1,8'hEF));

    // reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_busy", 16'(busy), 16'h0); chk("rst_we", 16'(we), 16'h0);
    chk("rst_re", 16'(re), 16'h0);     chk("rst_ma", MA, 16'h0);
    chk("rst_md", MD_in, 16'h0);       chk("rst_dout", 16'(cpu_dout), 16'h0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clock);
      row = i;
      cpu_wr = tbl[i].wr; cpu_rd = tbl[i].rd; cpu_a = tbl[i].a; cpu_din = tbl[i].din;
      incr_sel = tbl[i].isel; slot_avail = tbl[i].slot;
      #1;
      chk("busy", 16'(busy), 16'(tbl[i].busy));
      chk("we", 16'(we), 16'(tbl[i].we));
      chk("re", 16'(re), 16'(tbl[i].re));
      if (tbl[i].cma) chk("ma", MA, tbl[i].ma);
      if (tbl[i].cmd) chk("md_in", MD_in, tbl[i].md);
      if (tbl[i].cdo) chk("dout", 16'(cpu_dout), 16'(tbl[i].dout));
    end

    @(negedge clock);
    cpu_wr = 1'b0; cpu_rd = 1'b0; row = 1000;
    chk("mem1234", mem[16'h1234], 16'hABCD);
    chk("mem1235", mem[16'h1235], 16'h55CD);
    chk("mem1236", mem[16'h1236], 16'h77CD);
    chk("mem1237", mem[16'h1237], 16'h0000);
    chk("we_count", 16'(we_cnt), 16'd3);
    chk("re_count", 16'(re_cnt), 16'd3);

    // reset landing in the RD_WAIT cycle (ar=2, MARR=0x0040)
    row = 2000;
    cpu_rd = 1'b1; cpu_a = 2'd3; incr_sel = 2'd0; slot_avail = 1'b1;
    @(negedge clock);
    cpu_rd = 1'b0; #1;
    chk("rr_re", 16'(re), 16'h1); chk("rr_ma", MA, 16'h0041);
    @(negedge clock);
    reset = 1'b1; #1;
    chk("rr_wait_busy", 16'(busy), 16'h1); chk("rr_wait_re", 16'(re), 16'h0);
    @(negedge clock);
    reset = 1'b0; cpu_a = 2'd2; #1;
    chk("rr_vrr_lo", 16'(cpu_dout), 16'h0);
    chk("rr_busy", 16'(busy), 16'h0);
    chk("rr_ma0", MA, 16'h0);
    cpu_a = 2'd3; #1;
    chk("rr_vrr_hi", 16'(cpu_dout), 16'h0);
    cpu_a = 2'd0; #1;
    chk("rr_ar", 16'(cpu_dout), 16'h0);
    repeat (4) @(negedge clock);
    #1;
    chk("rr_no_re", 16'(re_cnt), 16'd4);
    chk("rr_ma_hold", MA, 16'h0);
    chk("re_we_excl", 16'(both_cnt), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_cpu_port.md
Name: vram_cpu_port

Overview:
- CPU-side VRAM access initiator inside the HuC6270 VDC.
- Implements the MAWR (write address), MARR (read address) and VWR/VRR (data) register path behind the 8-bit CPU bus.
- Drives the VRAM responder's MA/re/we/MD_in and captures its registered MD_out.
- Accesses are issued only in cycles where the render pipeline grants a VRAM slot.

Parameters:
- ADDR_W, 16, VRAM word-address width on MA; address registers wrap modulo 2**ADDR_W.
- DATA_W, 16, VRAM word width; fixed at 16 for the HuC6270, kept for bench reuse.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_a  in  2  CPU register select: 0 = address register (AR), 2 = data low byte, 3 = data high byte; 1 = unused (reads 0, writes ignored).
- cpu_wr  in  1  one-cycle CPU write strobe.
- cpu_rd  in  1  one-cycle CPU read strobe.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data, combinational from cpu_a.
- incr_sel  in  2  auto-increment select from CR bits 12:11: 0 = +1, 1 = +32, 2 = +64, 3 = +128.
- slot_avail  in  1  VRAM free for CPU access this cycle.
- MA  out  ADDR_W  VRAM address.
- re  out  1  VRAM read enable.
- we  out  1  VRAM write enable.
- MD_in  out  DATA_W  VRAM write data.
- MD_out  in  DATA_W  VRAM read data, valid the cycle after re.
- busy  out  1  an access is pending or in flight.

Behaviour:
- Registers:
  - ar[4:0] is written by cpu_a=0.
  - ar=0 selects MAWR, ar=1 selects MARR, ar=2 selects VWR (write) / VRR (read); other ar values are ignored.
  - A low-byte write (cpu_a=2) latches into the low half of the selected register. For VWR it latches into vwr_lo.
  - A high-byte write (cpu_a=3) latches into the high half.
- Read triggers:
  - A high-byte write to MARR sets a read trigger.
  - A cpu_rd with cpu_a=3 and ar=2 first adds inc to MARR and then sets a read trigger.
- Write trigger: a high-byte write to VWR sets a write trigger with data {cpu_din, vwr_lo}.
- inc is 1, 32, 64 or 128 per incr_sel, sampled at the moment of the increment. Sums wrap modulo 2**ADDR_W.
- cpu_dout:
  - cpu_a=0 returns {3'b0, ar}.
  - cpu_a=2 returns vrr[7:0] and cpu_a=3 returns vrr[15:8], regardless of ar.
  - cpu_a=1 returns 0.
- FSM states: IDLE, WR_PEND, RD_PEND, RD_WAIT.
- IDLE:
  - A write trigger moves to WR_PEND and latches wdata.
  - A read trigger moves to RD_PEND.
  - A trigger of either kind arriving while not IDLE is ignored.
- WR_PEND:
  - While slot_avail=0, hold with re=we=0.
  - When slot_avail=1, assert we=1, MA=MAWR, MD_in=wdata for exactly one cycle.
  - On the next edge MAWR += inc and return to IDLE.
- RD_PEND:
  - When slot_avail=1, assert re=1, MA=MARR for one cycle, then go to RD_WAIT.
- RD_WAIT:
  - Capture vrr <= MD_out (one-cycle VRAM latency) and return to IDLE.
  - MARR is not incremented on prefetch.
- busy = (state != IDLE).
- re and we are never asserted together. Outside an issuing cycle: MA holds its last value, MD_in holds wdata, and re=we=0.
- Same-cycle events:
  - A CPU write to MAWR or MARR low/high while not IDLE updates the register immediately.
  - A pending access uses the register value present in its issuing cycle.
  - A CPU write to MAWR in the same cycle as the post-write increment: the CPU write wins, and the increment is lost.
- Reset:
  - All registers and vrr are 0, state is IDLE, and MA=0, re=0, we=0, MD_in=0, busy=0.
  - Reset mid-operation abandons any pending or in-flight access with no VRAM strobe.
  - An MD_out capture in progress is discarded.

Optional Feature:
- Macro: VRAM_PORT_OVERRUN_EN.
- Defined:
  - Adds output overrun (1 bit), reset 0.
  - overrun is set when a trigger arrives while busy=1.
  - overrun is cleared by a cpu_rd with cpu_a=0, and that read returns {overrun, 2'b0, ar}.
  - If set and clear occur in the same cycle, set wins.
- Undefined: no overrun port; dropped triggers are silent, and cpu_a=0 reads return {3'b0, ar}.

Test Plan:
- Write sequence: ar=0, MAWR=0x1234; ar=2, lo=0xCD, hi=0xAB; incr_sel=0; slot_avail=1 -> one cycle later we=1, MA=0x1234, MD_in=0xABCD; then MAWR=0x1235 and busy=0.
- Slot stall: same write with slot_avail=0 for 5 cycles -> busy=1, we=0 throughout; we pulses exactly once in the first cycle slot_avail=1.
- Read prefetch: preload VRAM[0x0040]=0xBEEF; ar=1, MARR=0x0040 -> re=1 with MA=0x0040; two cycles later cpu_a=2 reads 0xEF and cpu_a=3 reads 0xBE.
- Read auto-increment with wrap: incr_sel=3, MARR=0xFFC0, read of cpu_a=3 -> MARR=0x0040 and a new re is issued at MA=0x0040.
- Trigger while busy: issue a VWR high write while WR_PEND with slot_avail=0 -> only the first write reaches VRAM; with VRAM_PORT_OVERRUN_EN, a cpu_a=0 read returns bit7=1, and the next such read returns bit7=0.
- Reset mid-read: assert reset in the RD_WAIT cycle -> vrr=0, busy=0, no further re, and MA=0.
